// File: rtl/cost_rom_arbiter.sv
// Round-robin arbiter that shares one Cost lookup port among NREQ permutation
// evaluators, walking workers 0..7 and returning the 10-bit total per grant.
module cost_rom_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [24*NREQ-1:0]   perm,
  output logic [NREQ-1:0]      ack,
  output logic [2:0]           W,
  output logic [2:0]           J,
  input  logic [6:0]           Cost,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [9:0]           rsp_sum,
  output logic                 busy
);

  localparam int GW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [9:0]          sum_q, sum_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [GW-1:0]       last_q, last_d;
  logic [23:0]         perm_q, perm_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [9:0]          rsp_sum_q, rsp_sum_d;
  logic [2:0]          w_q, w_d;
  logic [2:0]          j_q, j_d;
  logic                busy_q, busy_d;

  logic                found_s;
  logic [GW-1:0]       pick_s;
  logic [GW-1:0]       cand_s;
  logic [23:0]         perm_sel_s;

  function automatic logic [2:0] job_of(input logic [23:0] p, input logic [2:0] w);
    job_of = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w == 3'(i)) job_of = p[3*i +: 3];
    end
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] g);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << g;
  endfunction

  // Round-robin search starting just after the previous winner.
  always_comb begin
    found_s    = 1'b0;
    pick_s     = '0;
    cand_s     = '0;
    perm_sel_s = 24'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = GW'((int'(last_q) + k) % NREQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (pick_s == GW'(i)) perm_sel_s = perm[24*i +: 24];
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    perm_d      = perm_q;
    ack_d       = '0;
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;
    w_d         = 3'd0;
    j_d         = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          ack_d   = onehot(pick_s);
          perm_d  = perm_sel_s;
          gnt_d   = pick_s;
          last_d  = pick_s;
          idx_d   = 3'd0;
          sum_d   = 10'd0;
          j_d     = job_of(perm_sel_s, 3'd0);
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        sum_d = sum_q + {3'd0, Cost};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          rsp_sum_d   = sum_d;
          rsp_valid_d = onehot(gnt_q);
          state_d     = S_DONE;
        end else begin
          // W/J for the next worker are staged so the port is register-driven.
          w_d = idx_q + 3'd1;
          j_d = job_of(perm_q, idx_q + 3'd1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      sum_q       <= 10'd0;
      gnt_q       <= '0;
      last_q      <= GW'(NREQ - 1);
      perm_q      <= 24'd0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= 10'd0;
      w_q         <= 3'd0;
      j_q         <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      perm_q      <= perm_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      w_q         <= w_d;
      j_q         <= j_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign W         = w_q;
  assign J         = j_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Directed bench for cost_rom_arbiter: Cost = W*J model, scoreboard of expected
// responses pushed at grant time and popped when rsp_valid fires.
module tb_cost_rom_arbiter;
  localparam int NREQ = 2;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NREQ-1:0]    req;
  logic [24*NREQ-1:0] perm;
  logic [NREQ-1:0]    ack;
  logic [2:0]         W, J;
  logic [6:0]         Cost;
  logic [NREQ-1:0]    rsp_valid;
  logic [9:0]         rsp_sum;
  logic               busy;
  logic               cost_max = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [NREQ+9:0] sb[$];
  logic [NREQ+9:0] e;
  logic [23:0] id_perm, rev_perm;
  int n;

  cost_rom_arbiter #(.NREQ(NREQ)) dut (
    .CLK(CLK), .RST(RST), .req(req), .perm(perm), .ack(ack), .W(W), .J(J),
    .Cost(Cost), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .busy(busy)
  );

  always #5 CLK = ~CLK;

  assign Cost = cost_max ? 7'd127 : 7'({4'd0, W} * {4'd0, J});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [23:0] mk_perm(input bit rev);
    logic [23:0] p;
    p = 24'd0;
    for (int w = 0; w < 8; w++) p[3*w +: 3] = rev ? 3'(7 - w) : 3'(w);
    return p;
  endfunction

  function automatic logic [9:0] exp_sum(input logic [23:0] p);
    int s;
    s = 0;
    for (int w = 0; w < 8; w++) s += cost_max ? 127 : w * int'(p[3*w +: 3]);
    return 10'(s);
  endfunction

  task automatic wait_ack(input string tag, input int g, input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ack === '0 && cnt < budget);
    chk(tag, 32'(ack), 32'(1) << g);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    req = '0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // Scoreboard check of every response pulse.
  always @(negedge CLK) begin
    if (RST === 1'b0 && rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        chk("rsp_spurious", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e[NREQ+9:10]));
        chk("rsp_sum", 32'(rsp_sum), 32'(e[9:0]));
      end
    end
  end

  initial begin
    id_perm  = mk_perm(1'b0);
    rev_perm = mk_perm(1'b1);
    perm = '0;
    req  = '0;
    RST  = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_wj", {26'd0, W, J}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single request, identity permutation.
    perm[23:0] = id_perm;
    req = 2'b01;
    wait_ack("single_ack", 0, 4, n);
    chk("single_ack_latency", 32'(n), 32'd1);
    req = '0;
    sb.push_back({2'b01, exp_sum(id_perm)});
    for (int k = 0; k < 8; k++) begin
      chk("fetch_w", 32'(W), 32'(k));
      chk("fetch_j", 32'(J), 32'(k));
      chk("fetch_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("single_rsp_at_9", 32'(rsp_valid), 32'd1);
    chk("single_sum_140", 32'(rsp_sum), 32'd140);
    tick();
    chk("done_to_idle_busy", 32'(busy), 32'd0);
    chk("rsp_sum_held", 32'(rsp_sum), 32'd140);

    // Reverse permutation on requester 1.
    perm[47:24] = rev_perm;
    req = 2'b10;
    wait_ack("rev_ack", 1, 4, n);
    req = '0;
    sb.push_back({2'b10, exp_sum(rev_perm)});
    drain(20);

    // Simultaneous requests from reset.
    do_reset();
    req = 2'b11;
    wait_ack("simul_ack0", 0, 4, n);
    req[0] = 1'b0;
    sb.push_back({2'b01, exp_sum(id_perm)});
    wait_ack("simul_ack1", 1, 20, n);
    chk("simul_spacing", 32'(n), 32'd10);
    req[1] = 1'b0;
    sb.push_back({2'b10, exp_sum(rev_perm)});
    drain(20);

    // Persistent requests alternate grants.
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_ack("persist_ack", i % 2, 20, n);
      if (i > 0) chk("persist_spacing", 32'(n), 32'd10);
      sb.push_back({2'(1 << (i % 2)), (i % 2 == 0) ? exp_sum(id_perm) : exp_sum(rev_perm)});
    end
    req = '0;
    drain(30);

    // Maximum cost, no wrap.
    cost_max = 1'b1;
    req = 2'b01;
    wait_ack("max_ack", 0, 20, n);
    req = '0;
    sb.push_back({2'b01, exp_sum(id_perm)});
    drain(20);
    chk("max_sum_1016", 32'(rsp_sum), 32'd1016);
    cost_max = 1'b0;

    // Reset in the 4th FETCH cycle aborts the transaction.
    req = 2'b01;
    wait_ack("abort_ack", 0, 20, n);
    req = '0;
    tick();
    tick();
    tick();
    chk("abort_w_idx3", 32'(W), 32'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_outputs", {17'd0, ack, W, J, rsp_valid, busy}, 32'd0);
    chk("abort_rsp_sum", 32'(rsp_sum), 32'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("abort_idle", 32'(busy), 32'd0);
    req = 2'b01;
    wait_ack("post_abort_ack", 0, 4, n);
    req = '0;
    sb.push_back({2'b01, exp_sum(id_perm)});
    drain(20);
    chk("post_abort_sum", 32'(rsp_sum), 32'd140);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
